// File: rtl/matrix_3x3_pkg.sv
// Shared definitions for the matrix_3x3 line pipeline.
// Provides default pixel/line geometry and the line-reader FSM state type.
`timescale 1ns/1ps
package matrix_3x3_pkg;

    localparam int unsigned PIXEL_WIDTH = 10;
    localparam int unsigned LINE_LEN    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Small register FIFO that absorbs returned FIFO reads ahead of the stream port.
// Entry 0 is always the head, so the head word and its valid come straight
// from flops.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push, push_data       write one entry
//   pop                   remove the head entry (may coincide with push, even when full)
//   head_data, head_valid current head entry
//   occupancy             number of valid entries
`timescale 1ns/1ps
module rd_skid_buf #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           head_valid,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;

    // Shift toward the head on pop, then write the new word just past the survivors.
    always_comb begin
        base  = cnt_q - CNT_W'(pop);
        cnt_d = base + CNT_W'(push);
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            mem_d[i] = pop ? mem_q[i+1] : mem_q[i];
        end
        mem_d[DEPTH-1] = pop ? '0 : mem_q[DEPTH-1];
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && (base == CNT_W'(i))) begin
                mem_d[i] = push_data;
            end
        end
        // Empty slots are zeroed so no stale marker bit can ride on an invalid head.
        for (int i = 0; i < int'(DEPTH); i++) begin
            vld_d[i] = (CNT_W'(i) < cnt_d);
            if (!vld_d[i]) begin
                mem_d[i] = '0;
            end
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data  = mem_q[0];
    assign head_valid = vld_q[0];
    assign occupancy  = cnt_q;

endmodule

// File: rtl/fifo_line_reader.sv
// Read-side controller for the matrix_3x3 pixel line FIFOs. A start pulse pops
// exactly LINE_LEN pixels and streams them out with valid/ready and a last flag,
// absorbing the FIFO read latency and downstream backpressure.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           request one line (ignored while busy)
//   busy, done                      line in progress / one-cycle completion pulse
//   fifo_rd_en                      FIFO pop (combinational)
//   fifo_rd_data, fifo_empty        FIFO read data and empty flag
//   m_data, m_valid, m_last         output stream (registered)
//   m_ready                         downstream ready
`timescale 1ns/1ps
module fifo_line_reader
    import matrix_3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = matrix_3x3_pkg::PIXEL_WIDTH,
    parameter int unsigned LINE_LEN   = matrix_3x3_pkg::LINE_LEN,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned SKID_DEPTH = RD_LATENCY + 1;
    localparam int unsigned CNT_W      = $clog2(LINE_LEN + 1);
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);
    localparam int unsigned SUM_W      = OCC_W + 1;
    localparam int unsigned BEAT_W     = DATA_WIDTH + 1;

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [CNT_W-1:0]      issued_q;
    logic [CNT_W-1:0]      sent_q;
    logic [OCC_W-1:0]      inflight_q;
    logic [OCC_W-1:0]      occ;
    logic [RD_LATENCY-1:0] rv_q;
    logic [RD_LATENCY-1:0] rl_q;
    logic [SUM_W-1:0]      credit_sum;
    logic                  credit_ok;
    logic                  start_ok;
    logic                  last_issue;
    logic                  last_hs;
    logic                  pop;
    logic                  push;
    logic [BEAT_W-1:0]     push_beat;
    logic [BEAT_W-1:0]     head_beat;
    logic                  head_valid;

    assign pop        = head_valid && m_ready;
    assign start_ok   = (state_q == IDLE) && start;
    assign last_issue = (issued_q == CNT_W'(LINE_LEN - 1));
    assign last_hs    = pop && (sent_q == CNT_W'(LINE_LEN - 1));

    // A read may issue only if every word already owed still fits in the buffer;
    // a pop in this cycle frees its slot in time.
    assign credit_sum = SUM_W'(inflight_q) + SUM_W'(occ) - SUM_W'(pop);
    assign credit_ok  = (credit_sum < SUM_W'(SKID_DEPTH));

    assign fifo_rd_en = (state_q == READ) && !fifo_empty
                        && (issued_q < CNT_W'(LINE_LEN)) && credit_ok;

    // Returned data is tagged at issue time with its end-of-line flag.
    assign push      = rv_q[RD_LATENCY-1];
    assign push_beat = {rl_q[RD_LATENCY-1], fifo_rd_data};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (issued_q == CNT_W'(LINE_LEN)) state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == DRAIN) && last_hs;
        end
    end

    // Issue/accept counters and the read-return tracking pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= '0;
            rv_q       <= '0;
            rl_q       <= '0;
        end else begin
            if (start_ok) begin
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (fifo_rd_en) issued_q <= issued_q + CNT_W'(1);
                if (pop)        sent_q   <= sent_q + CNT_W'(1);
            end
            inflight_q <= inflight_q + OCC_W'(fifo_rd_en) - OCC_W'(push);
            for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
                rv_q[i] <= rv_q[i-1];
                rl_q[i] <= rl_q[i-1];
            end
            rv_q[0] <= fifo_rd_en;
            rl_q[0] <= fifo_rd_en && last_issue;
        end
    end

    rd_skid_buf #(
        .WIDTH (BEAT_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_beat),
        .pop        (pop),
        .head_data  (head_beat),
        .head_valid (head_valid),
        .occupancy  (occ)
    );

    assign m_valid = head_valid;
    assign m_data  = head_beat[DATA_WIDTH-1:0];
    assign m_last  = head_beat[DATA_WIDTH];

endmodule

// File: tb/tb_fifo_line_reader.sv
// Bench for fifo_line_reader: two instances (read latency 1 and 2), each fed by
// a behavioural sync FIFO. Words written into a FIFO are pushed to an expected
// queue and popped at each stream handshake.
`timescale 1ns/1ps
module tb_fifo_line_reader;

    localparam int DW = 10;
    localparam int LL = 16;

    typedef struct {
        int preload;     // words written before start
        int late_n;      // words written after start
        int late_delay;  // cycles after start before late writes
        int ready_mode;  // 0 = always ready, 1 = toggling
        int do_start;
        int restart_at;  // cycle of a second start pulse (0 = none)
        int lat_chk;
        int exp_beats;
        int exp_done;
        int exp_left;
        int exp_busy;
    } case_t;

    logic clk_tb = 1'b0;
    logic tb_rst;
    always #5 clk_tb = ~clk_tb;

    logic          start      [2];
    logic          busy       [2];
    logic          done       [2];
    logic          fifo_rd_en [2];
    logic          fifo_empty [2];
    logic [DW-1:0] fifo_rd_data [2];
    logic [DW-1:0] m_data     [2];
    logic          m_valid    [2];
    logic          m_last     [2];
    logic          m_ready    [2];
    logic          wr_en      [2];
    logic [DW-1:0] wr_data    [2];
    int            fifo_count [2];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [DW-1:0] q[$];
        logic [DW-1:0] st0 = '0;
        logic [DW-1:0] st1 = '0;
        logic          emp = 1'b1;
        int            cnt = 0;

        fifo_line_reader #(
            .DATA_WIDTH (DW),
            .LINE_LEN   (LL),
            .RD_LATENCY (g + 1)
        ) u_dut (
            .clk          (clk_tb),
            .rst_n        (tb_rst),
            .start        (start[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .fifo_rd_en   (fifo_rd_en[g]),
            .fifo_rd_data (fifo_rd_data[g]),
            .fifo_empty   (fifo_empty[g]),
            .m_data       (m_data[g]),
            .m_valid      (m_valid[g]),
            .m_last       (m_last[g]),
            .m_ready      (m_ready[g])
        );

        // Sync FIFO model: output register chain gives the configured read latency.
        always @(posedge clk_tb or negedge tb_rst) begin
            if (!tb_rst) begin
                q.delete();
                st0 <= '0;
                st1 <= '0;
                emp <= 1'b1;
                cnt <= 0;
            end else begin
                logic [DW-1:0] w;
                w = st0;
                if (fifo_rd_en[g] && q.size() > 0) w = q.pop_front();
                if (wr_en[g]) q.push_back(wr_data[g]);
                st0 <= w;
                st1 <= st0;
                emp <= (q.size() == 0);
                cnt <= q.size();
            end
        end

        assign fifo_rd_data[g] = (g == 0) ? st0 : st1;
        assign fifo_empty[g]   = emp;
        assign fifo_count[g]   = cnt;
    end

    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            k = 0;
    int            beats, dones, line_beat;
    int            start_cyc, first_cyc, done_cyc;
    int            ready_mode = 0;
    int            wr_delay = 0;
    int            next_word = 1;
    logic          in_line = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    case_t         cases[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (lane %0d, cyc %0d): got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // One clock: drive after the rising edge, observe on the falling edge.
    task automatic tick(input logic do_start);
        logic [DW-1:0] e;
        @(posedge clk_tb);
        #1;
        start[k] = do_start;
        if (do_start && !in_line) begin
            in_line   = 1'b1;
            line_beat = 0;
            start_cyc = cyc + 1;
            first_cyc = -1;
            done_cyc  = -1;
        end
        wr_en[k] = 1'b0;
        if (wr_delay > 0) begin
            wr_delay--;
        end else if (wq.size() > 0) begin
            wr_en[k]   = 1'b1;
            wr_data[k] = wq.pop_front();
            exp_q.push_back(wr_data[k]);
        end
        m_ready[k] = (ready_mode == 0) ? 1'b1 : cyc[0];
        @(negedge clk_tb);
        cyc++;
        if (fifo_rd_en[k]) check("rd_en_while_empty", int'(fifo_empty[k]), 0);
        if (prev_stall) begin
            check("stall_valid", int'(m_valid[k]), 1);
            check("stall_data", int'(m_data[k]), int'(prev_data));
        end
        if (m_valid[k] && first_cyc < 0) first_cyc = cyc;
        if (m_valid[k] && m_ready[k]) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_beat (lane %0d, cyc %0d): got data %0d with no word expected",
                         k, cyc, m_data[k]);
            end else begin
                n_cmp--;
                e = exp_q.pop_front();
                check("beat_data", int'(m_data[k]), int'(e));
                check("beat_last", int'(m_last[k]), int'(line_beat == LL - 1));
            end
            line_beat++;
            beats++;
        end
        prev_stall = m_valid[k] && !m_ready[k];
        prev_data  = m_data[k];
        if (done[k]) begin
            dones++;
            done_cyc = cyc;
            in_line  = 1'b0;
        end
    endtask

    task automatic run_case(input case_t c);
        beats      = 0;
        dones      = 0;
        prev_stall = 1'b0;
        ready_mode = c.ready_mode;
        wr_delay   = 0;
        for (int i = 0; i < c.preload; i++) begin
            wq.push_back(DW'(next_word));
            next_word++;
        end
        repeat (c.preload + 3) tick(1'b0);
        wr_delay = c.late_delay;
        for (int i = 0; i < c.late_n; i++) begin
            wq.push_back(DW'(next_word));
            next_word++;
        end
        tick(c.do_start != 0);
        for (int t = 1; t < 60; t++) tick(t == c.restart_at);
        check("beats", beats, c.exp_beats);
        check("dones", dones, c.exp_done);
        if (c.do_start != 0) check("first_valid_lat", first_cyc - start_cyc, k + 1 + 2);
        if (c.lat_chk != 0) check("start_to_done", done_cyc - start_cyc, LL + (k + 1) + 2);
        check("fifo_left", fifo_count[k], c.exp_left);
        check("busy_after", int'(busy[k]), c.exp_busy);
        ready_mode = 0;
    endtask

    task automatic check_outputs_zero(input int lane, input string tag);
        check({tag, "_busy"},    int'(busy[lane]), 0);
        check({tag, "_done"},    int'(done[lane]), 0);
        check({tag, "_rd_en"},   int'(fifo_rd_en[lane]), 0);
        check({tag, "_m_valid"}, int'(m_valid[lane]), 0);
        check({tag, "_m_last"},  int'(m_last[lane]), 0);
        check({tag, "_m_data"},  int'(m_data[lane]), 0);
    endtask

    initial begin
        //          pre late dly rdy st  rs lat beats dn left busy
        cases[0] = '{16,  0,  0,  0, 1,  0, 1,  16,  1,  0,  0};  // straight line
        cases[1] = '{16,  0,  0,  1, 1,  0, 0,  16,  1,  0,  0};  // toggling ready
        cases[2] = '{ 8,  8, 20,  0, 1,  0, 0,  16,  1,  0,  0};  // empty mid-line
        cases[3] = '{20,  0,  0,  0, 1,  0, 1,  16,  1,  4,  0};  // overfilled FIFO
        cases[4] = '{ 0,  0,  0,  0, 1,  0, 0,   4,  0,  0,  1};  // leftovers, then stall
        cases[5] = '{ 0, 12,  5,  0, 0,  0, 0,  12,  1,  0,  0};  // rest of that line
        cases[6] = '{16,  0,  0,  0, 1,  6, 1,  16,  1,  0,  0};  // start while busy

        for (int i = 0; i < 2; i++) begin
            start[i]   = 1'b0;
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
            m_ready[i] = 1'b1;
        end
        tb_rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            k = i;
            check_outputs_zero(i, "reset");
        end
        repeat (2) @(posedge clk_tb);
        #1 tb_rst = 1'b1;

        for (int lane = 0; lane < 2; lane++) begin
            k = lane;
            for (int c = 0; c < 7; c++) run_case(cases[c]);

            // Reset in the middle of a line.
            beats = 0;
            for (int i = 0; i < LL; i++) begin
                wq.push_back(DW'(next_word));
                next_word++;
            end
            repeat (LL + 3) tick(1'b0);
            tick(1'b1);
            for (int t = 0; t < 100 && beats < 5; t++) tick(1'b0);
            check("reached_beat5", beats, 5);
            #2 tb_rst = 1'b0;
            #1 check_outputs_zero(lane, "midline_reset");
            wq.delete();
            exp_q.delete();
            in_line    = 1'b0;
            prev_stall = 1'b0;
            @(posedge clk_tb);
            #1 tb_rst = 1'b1;
            tick(1'b0);
            check("busy_after_reset", int'(busy[lane]), 0);
            check("fifo_after_reset", fifo_count[lane], 0);
            run_case(cases[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
